// File: rtl/bm_rd_ctrl_pkg.sv
// rtl/bm_rd_ctrl_pkg.sv - shared BM geometry and latency-tag type for the BM read path
package bm_rd_ctrl_pkg;

  // Bias memory geometry and pipeline depth shared with the BM instance
  localparam int BM_DATA_WIDTH = 16;
  localparam int BM_DEPTH      = 512;
  localparam int BM_NUM_PIPE   = 1;

  // Tag travelling alongside a read through the BM pipe
  typedef struct packed {
    logic vld;
    logic last;
  } lat_tag_t;

endpackage

// File: rtl/bm_rd_fifo.sv
// rtl/bm_rd_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module bm_rd_fifo
  import bm_rd_ctrl_pkg::*;
#(
  parameter int WIDTH  = BM_DATA_WIDTH + 1,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Writes beyond capacity and pops of an empty FIFO are dropped defensively
  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage array needs no reset: the head is only observed when count is non-zero
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/bm_rd_ctrl.sv
// rtl/bm_rd_ctrl.sv - BM burst read sequencer with latency alignment and credit-limited output FIFO
module bm_rd_ctrl
  import bm_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = BM_DATA_WIDTH,
  parameter int DEPTH      = BM_DEPTH,
  parameter int RD_LAT     = BM_NUM_PIPE + 1,
  parameter int FIFO_DEPTH = RD_LAT + 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW-1:0]         cmd_len,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int         CW      = $clog2(FIFO_DEPTH + 1);

  // Every read in the BM pipe must have a guaranteed FIFO slot when it lands
  if (FIFO_DEPTH < RD_LAT + 1) begin : g_bad_fifo_depth
    $error("bm_rd_ctrl: FIFO_DEPTH must be at least RD_LAT+1");
  end

  logic [1:0]            r_state;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         r_rem;
  lat_tag_t              r_tag [RD_LAT];
  logic [CW-1:0]         w_inflight;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_occ;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_empty;
  logic [DATA_WIDTH:0]   w_head;
  lat_tag_t              w_exit;

  // Count reads still travelling through the BM pipe
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_tag[i].vld);
  end

  assign w_occ    = {1'b0, w_inflight} + {1'b0, w_count};
  assign w_credit = w_occ < (CW + 1)'(FIFO_DEPTH);
  assign w_issue  = (r_state == S_ISSUE) && w_credit;
  assign w_exit   = r_tag[RD_LAT-1];
  assign w_pop    = !w_empty && out_ready;

  // Burst FSM: capture command, issue one address per credited cycle, wait for the last pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_rem   <= cmd_len;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
            if (r_rem == '0) r_state <= S_DRAIN;
            else             r_rem   <= r_rem - AW'(1);
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head[DATA_WIDTH]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag shift register mirrors the BM pipe so the tag exits alongside its data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= {w_issue, w_issue && (r_rem == '0)};
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  bm_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_exit.vld),
    .i_data  ({w_exit.last, mem_dout}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign out_last    = !w_empty && w_head[DATA_WIDTH];

endmodule
